// File: rtl/camera_wr_arbiter_pkg.sv
// Shared types and defaults for the camera write-port arbiter.
// The optional watchdog is enabled by defining CAMERA_ARB_WATCHDOG_EN.
package camera_arb_pkg;

  localparam int DEF_NUM_CAM   = 3;
  localparam int DEF_ADDR_W    = 29;
  localparam int DEF_DATA_W    = 128;
  localparam int DEF_COUNT_W   = 9;
  localparam int DEF_BURST_LEN = 8;
  localparam int DEF_TIMEOUT   = 1024;
  localparam int MAX_CAM       = 8;
  localparam int IDX_W         = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  // OR-reduction encoder; the caller guarantees at most one bit is set.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_CAM-1:0] onehot);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_CAM; i++) begin
      if (onehot[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/camera_wr_arbiter_if.sv
// Camera-side and memory-side write handshake bundle for the arbiter.
// master = arbiter view, slave = cameras plus memory controller view.
interface camera_wr_arbiter_if
  import camera_arb_pkg::*;
#(
  parameter int NUM_CAM = DEF_NUM_CAM,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int COUNT_W = DEF_COUNT_W
) ();

  logic [NUM_CAM-1:0]         cam_wr_req;
  logic [NUM_CAM*ADDR_W-1:0]  cam_wr_addr;
  logic [NUM_CAM*DATA_W-1:0]  cam_wdf_data;
  logic [NUM_CAM*COUNT_W-1:0] cam_fifo_count;
  logic [NUM_CAM-1:0]         cam_wr_ack;
  logic [NUM_CAM-1:0]         cam_wdata_rd_en;
  logic                       mem_wr_req;
  logic [ADDR_W-1:0]          mem_wr_addr;
  logic                       mem_wr_ack;
  logic                       mem_wdata_rd_en;
  logic [DATA_W-1:0]          mem_wdf_data;

  modport master (
    input  cam_wr_req, cam_wr_addr, cam_wdf_data, cam_fifo_count,
    input  mem_wr_ack, mem_wdata_rd_en,
    output cam_wr_ack, cam_wdata_rd_en,
    output mem_wr_req, mem_wr_addr, mem_wdf_data
  );

  modport slave (
    output cam_wr_req, cam_wr_addr, cam_wdf_data, cam_fifo_count,
    output mem_wr_ack, mem_wdata_rd_en,
    input  cam_wr_ack, cam_wdata_rd_en,
    input  mem_wr_req, mem_wr_addr, mem_wdf_data
  );

endinterface

// File: rtl/camera_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first eligible requester at or
// after ptr, wrapping to the lowest index when none lies above it.
module rr_pick #(
  parameter int NUM_CAM = 3,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_CAM-1:0] eligible,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_CAM-1:0] pick
);

  logic [NUM_CAM-1:0] w_upper;
  logic [NUM_CAM-1:0] w_src;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CAM; gi++) begin : g_upper
      assign w_upper[gi] = eligible[gi] && (PTR_W'(gi) >= ptr);
    end
  endgenerate

  // Isolate the lowest set bit of the chosen half.
  assign w_src = (|w_upper) ? w_upper : eligible;
  assign pick  = w_src & (~w_src + NUM_CAM'(1));

endmodule

// File: rtl/camera_wr_arbiter.sv
// Round-robin arbiter sharing one memory write command/data port among cameras.
// Define CAMERA_ARB_WATCHDOG_EN to abort bursts stalled for TIMEOUT cycles.
module camera_wr_arbiter
  import camera_arb_pkg::*;
#(
  parameter int NUM_CAM   = DEF_NUM_CAM,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int COUNT_W   = DEF_COUNT_W,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                mem_clk,
  input  logic                mem_reset_n,
  camera_wr_arbiter_if.master wr_if,
  output logic [COUNT_W-1:0]  fifo_rd_data_count,
  output logic [NUM_CAM-1:0]  grant,
  output logic                busy,
  output logic                proto_err
);

  localparam int PTR_W  = (NUM_CAM > 1) ? $clog2(NUM_CAM) : 1;
  localparam int BEAT_W = $clog2(BURST_LEN + 1);

  arb_state_e         r_state, w_state_next;
  logic [NUM_CAM-1:0] r_grant, w_grant_next;
  logic [NUM_CAM-1:0] w_eligible, w_pick;
  logic [NUM_CAM-1:0] w_cam_ack, w_cam_rd_en;
  logic [PTR_W-1:0]   r_ptr, w_ptr_next, w_g_idx, w_ptr_after;
  logic [BEAT_W-1:0]  r_beat, w_beat_next;
  logic [ADDR_W-1:0]  r_addr, w_addr_next, w_pick_addr;
  logic               r_proto_err, w_err_next;
  logic               w_mem_req;
  logic [DATA_W-1:0]  w_wdf_data;
  logic [COUNT_W-1:0] w_count;

`ifdef CAMERA_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] r_wd, w_wd_next;
`else
  // TIMEOUT only matters with the watchdog; keep its range visible here.
  if (TIMEOUT < 1) begin : g_timeout_range
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CAM; gi++) begin : g_elig
      assign w_eligible[gi] = wr_if.cam_wr_req[gi] &&
        (wr_if.cam_fifo_count[gi*COUNT_W +: COUNT_W] >= COUNT_W'(BURST_LEN));
    end
  endgenerate

  rr_pick #(.NUM_CAM(NUM_CAM), .PTR_W(PTR_W)) u_rr_pick (
    .eligible (w_eligible),
    .ptr      (r_ptr),
    .pick     (w_pick)
  );

  always_comb begin
    w_pick_addr = '0;
    w_wdf_data  = '0;
    w_count     = '0;
    for (int k = 0; k < NUM_CAM; k++) begin
      if (w_pick[k]) w_pick_addr = w_pick_addr | wr_if.cam_wr_addr[k*ADDR_W +: ADDR_W];
      if (r_grant[k]) begin
        w_wdf_data = w_wdf_data | wr_if.cam_wdf_data[k*DATA_W +: DATA_W];
        w_count    = w_count | wr_if.cam_fifo_count[k*COUNT_W +: COUNT_W];
      end
    end
  end

  assign w_g_idx     = PTR_W'(onehot_to_idx(MAX_CAM'(r_grant)));
  assign w_ptr_after = (w_g_idx == PTR_W'(NUM_CAM - 1)) ? '0 : w_g_idx + 1'b1;

  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant;
    w_ptr_next   = r_ptr;
    w_beat_next  = r_beat;
    w_addr_next  = r_addr;
    w_err_next   = r_proto_err;
    w_cam_ack    = '0;
    w_cam_rd_en  = '0;
    w_mem_req    = 1'b0;
    case (r_state)
      IDLE: begin
        if (wr_if.mem_wdata_rd_en || wr_if.mem_wr_ack) w_err_next = 1'b1;
        if (|w_eligible) begin
          w_grant_next = w_pick;
          w_addr_next  = w_pick_addr;
          w_state_next = CMD;
        end
      end
      CMD: begin
        w_mem_req = 1'b1;
        if (wr_if.mem_wdata_rd_en) w_err_next = 1'b1;
        if (wr_if.mem_wr_ack) begin
          w_cam_ack    = r_grant;
          w_beat_next  = '0;
          w_state_next = DATA;
        end
      end
      DATA: begin
        if (wr_if.mem_wr_ack) w_err_next = 1'b1;
        if (wr_if.mem_wdata_rd_en) begin
          w_cam_rd_en = r_grant;
          if (r_beat == BEAT_W'(BURST_LEN - 1)) begin
            w_beat_next  = '0;
            w_grant_next = '0;
            w_ptr_next   = w_ptr_after;
            w_state_next = IDLE;
          end else begin
            w_beat_next = r_beat + 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
`ifdef CAMERA_ARB_WATCHDOG_EN
    w_wd_next = '0;
    if (r_state != IDLE && !wr_if.mem_wr_ack && !wr_if.mem_wdata_rd_en) begin
      if (r_wd == WD_W'(TIMEOUT - 1)) begin
        w_err_next   = 1'b1;
        w_state_next = IDLE;
        w_grant_next = '0;
        w_beat_next  = '0;
        w_ptr_next   = w_ptr_after;
      end else begin
        w_wd_next = r_wd + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge mem_clk) begin
    if (!mem_reset_n) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_ptr       <= '0;
      r_beat      <= '0;
      r_addr      <= '0;
      r_proto_err <= 1'b0;
`ifdef CAMERA_ARB_WATCHDOG_EN
      r_wd        <= '0;
`endif
    end else begin
      r_state     <= w_state_next;
      r_grant     <= w_grant_next;
      r_ptr       <= w_ptr_next;
      r_beat      <= w_beat_next;
      r_addr      <= w_addr_next;
      r_proto_err <= w_err_next;
`ifdef CAMERA_ARB_WATCHDOG_EN
      r_wd        <= w_wd_next;
`endif
    end
  end

  assign wr_if.cam_wr_ack      = w_cam_ack;
  assign wr_if.cam_wdata_rd_en = w_cam_rd_en;
  assign wr_if.mem_wr_req      = w_mem_req;
  assign wr_if.mem_wr_addr     = r_addr;
  assign wr_if.mem_wdf_data    = w_wdf_data;
  assign fifo_rd_data_count    = w_count;
  assign grant                 = r_grant;
  assign busy                  = (r_state != IDLE);
  assign proto_err             = r_proto_err;

endmodule
